// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Parses a framed boot image arriving byte-by-byte from the UART receiver
//   and writes 16-bit Hack instruction words into instruction memory.
//   The Hack CPU is held in reset while a frame is being loaded. It stays
//   held if the load fails.
//
//   Frame: SYNC, LEN_HI, LEN_LO, LEN x (HI, LO), CHK
//   CHK = 8-bit sum of LEN_HI, LEN_LO and all data bytes (SYNC excluded).
//
// Ports:
//   i_CLK        system clock
//   i_RESET_n    asynchronous active-low reset
//   i_RX_DV      one-clock byte-valid pulse from the UART receiver
//   i_Rx_Data    received byte, valid while i_RX_DV=1
//   o_ROM_WE     one-clock ROM write strobe
//   o_ROM_Addr   ROM write address
//   o_ROM_Data   ROM write data
//   o_CPU_Hold   1 = hold the CPU in reset
//   o_Busy       frame in progress
//   o_Done       last frame loaded with a good checksum (sticky)
//   o_Error      last frame failed (sticky)

module uart_rom_loader #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_n,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_Rx_Data,
  output logic                  o_ROM_WE,
  output logic [ADDR_WIDTH-1:0] o_ROM_Addr,
  output logic [15:0]           o_ROM_Data,
  output logic                  o_CPU_Hold,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK
  } state_t;

  state_t                state, state_next;
  logic [15:0]           len, len_next;
  logic [16:0]           word_cnt, word_cnt_next;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic [7:0]            data_hi, data_hi_next;
  logic [7:0]            checksum, checksum_next;
  logic [TO_WIDTH-1:0]   to_cnt, to_cnt_next;
  logic                  rom_we_next;
  logic [ADDR_WIDTH-1:0] rom_addr_next;
  logic [15:0]           rom_data_next;
  logic                  hold_next, busy_next, done_next, error_next;
  logic                  abort;
  logic [15:0]           len_full;
  logic [16:0]           word_cnt_inc;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state      <= S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      addr       <= '0;
      data_hi    <= '0;
      checksum   <= '0;
      to_cnt     <= '0;
      o_ROM_WE   <= 1'b0;
      o_ROM_Addr <= '0;
      o_ROM_Data <= '0;
      o_CPU_Hold <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Error    <= 1'b0;
    end else begin
      state      <= state_next;
      len        <= len_next;
      word_cnt   <= word_cnt_next;
      addr       <= addr_next;
      data_hi    <= data_hi_next;
      checksum   <= checksum_next;
      to_cnt     <= to_cnt_next;
      o_ROM_WE   <= rom_we_next;
      o_ROM_Addr <= rom_addr_next;
      o_ROM_Data <= rom_data_next;
      o_CPU_Hold <= hold_next;
      o_Busy     <= busy_next;
      o_Done     <= done_next;
      o_Error    <= error_next;
    end
  end

  always_comb begin
    state_next    = state;
    len_next      = len;
    word_cnt_next = word_cnt;
    addr_next     = addr;
    data_hi_next  = data_hi;
    checksum_next = checksum;
    to_cnt_next   = to_cnt;
    rom_we_next   = 1'b0;
    rom_addr_next = o_ROM_Addr;
    rom_data_next = o_ROM_Data;
    hold_next     = o_CPU_Hold;
    busy_next     = o_Busy;
    done_next     = o_Done;
    error_next    = o_Error;
    abort         = 1'b0;
    len_full      = {len[15:8], i_Rx_Data};
    word_cnt_inc  = word_cnt + 17'd1;

    if (state == S_IDLE) begin
      to_cnt_next = '0;
      if (i_RX_DV && (i_Rx_Data == SYNC_BYTE)) begin
        state_next    = S_LEN_HI;
        done_next     = 1'b0;
        error_next    = 1'b0;
        hold_next     = 1'b1;
        busy_next     = 1'b1;
        checksum_next = '0;
        addr_next     = '0;
        word_cnt_next = '0;
      end
    end else if (i_RX_DV) begin
      // An arriving byte always beats a timeout expiring on the same cycle.
      to_cnt_next = '0;
      case (state)
        S_LEN_HI: begin
          len_next      = {i_Rx_Data, len[7:0]};
          checksum_next = checksum + i_Rx_Data;
          state_next    = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_next      = len_full;
          checksum_next = checksum + i_Rx_Data;
          // A length that would not fit in memory is rejected before any
          // write, so the address counter can never wrap.
          if ({1'b0, len_full} > DEPTH) begin
            abort = 1'b1;
          end else if (len_full == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          data_hi_next  = i_Rx_Data;
          checksum_next = checksum + i_Rx_Data;
          state_next    = S_DATA_LO;
        end
        S_DATA_LO: begin
          checksum_next = checksum + i_Rx_Data;
          rom_we_next   = 1'b1;
          rom_addr_next = addr;
          rom_data_next = {data_hi, i_Rx_Data};
          addr_next     = addr + ADDR_WIDTH'(1);
          word_cnt_next = word_cnt_inc;
          if (word_cnt_inc == {1'b0, len}) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA_HI;
          end
        end
        S_CHECK: begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
          if (i_Rx_Data == checksum) begin
            done_next = 1'b1;
            hold_next = 1'b0;
          end else begin
            error_next = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (to_cnt == TO_LIMIT) begin
      abort = 1'b1;
    end else begin
      to_cnt_next = to_cnt + TO_WIDTH'(1);
    end

    // A failed frame leaves the CPU held; partially written memory is kept.
    if (abort) begin
      error_next  = 1'b1;
      busy_next   = 1'b0;
      state_next  = S_IDLE;
      to_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader
//   Directed byte frames into uart_rom_loader. Expected ROM writes are
//   queued by the stimulus and matched by a write monitor; status outputs
//   are compared against hand-computed values after each frame.

module tb_uart_rom_loader;

  localparam int AW = 15;

  logic          i_CLK = 1'b0;
  logic          i_RESET_n = 1'b0;
  logic          i_RX_DV = 1'b0;
  logic [7:0]    i_Rx_Data = 8'h00;
  logic          o_ROM_WE;
  logic [AW-1:0] o_ROM_Addr;
  logic [15:0]   o_ROM_Data;
  logic          o_CPU_Hold;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Error;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t expQ[$];
  wr_t monExp;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  lastDv = -1;
  int  e0;

  uart_rom_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'h55),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_CLK     (i_CLK),
    .i_RESET_n (i_RESET_n),
    .i_RX_DV   (i_RX_DV),
    .i_Rx_Data (i_Rx_Data),
    .o_ROM_WE  (o_ROM_WE),
    .o_ROM_Addr(o_ROM_Addr),
    .o_ROM_Data(o_ROM_Data),
    .o_CPU_Hold(o_CPU_Hold),
    .o_Busy    (o_Busy),
    .o_Done    (o_Done),
    .o_Error   (o_Error)
  );

  always #5 i_CLK = ~i_CLK;

  always @(posedge i_CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Status vector is {busy, hold, done, error}.
  task automatic checkStatus(input string name, input logic [3:0] exp);
    checkOutput(name, {28'd0, o_Busy, o_CPU_Hold, o_Done, o_Error}, {28'd0, exp});
  endtask

  // Drives one byte-valid pulse sampled by the next rising edge, then idles a few clocks.
  task automatic applyStimulus(input logic [7:0] b);
    i_Rx_Data = b;
    i_RX_DV = 1'b1;
    @(posedge i_CLK);
    #1;
    lastDv = cyc;
    @(negedge i_CLK);
    i_RX_DV = 1'b0;
    repeat (3) @(negedge i_CLK);
  endtask

  task automatic expectWrite(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    expQ.push_back(w);
  endtask

  // Every write strobe must match the oldest expected write and appear on
  // the clock right after the LO byte was taken.
  always @(negedge i_CLK) begin
    if (o_ROM_WE) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=addr %h data %h expected=no write", o_ROM_Addr, o_ROM_Data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("write_addr", {17'd0, o_ROM_Addr}, {17'd0, monExp.addr});
        checkOutput("write_data", {16'd0, o_ROM_Data}, {16'd0, monExp.data});
        checkOutput("write_latency", cyc, lastDv);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendGoodFrame();
    applyStimulus(8'h55);
    checkStatus("sync_busy_hold", 4'b1100);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    expectWrite(15'd0, 16'h1234);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    expectWrite(15'd1, 16'hABCD);
    applyStimulus(8'hCD);
    applyStimulus(8'hC0);
    checkStatus("good_frame_done", 4'b0010);
  endtask

  initial begin
    repeat (3) @(negedge i_CLK);
    checkStatus("reset_status", 4'b0000);
    checkOutput("reset_we", {31'd0, o_ROM_WE}, 32'd0);
    checkOutput("reset_addr", {17'd0, o_ROM_Addr}, 32'd0);
    checkOutput("reset_data", {16'd0, o_ROM_Data}, 32'd0);
    i_RESET_n = 1'b1;
    @(negedge i_CLK);

    // Good two-word frame
    sendGoodFrame();

    // Same frame, bad checksum: both writes still happen
    applyStimulus(8'h55);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    expectWrite(15'd0, 16'h1234);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    expectWrite(15'd1, 16'hABCD);
    applyStimulus(8'hCD);
    applyStimulus(8'hC1);
    checkStatus("bad_chk_error", 4'b0101);

    // Noise in IDLE is ignored; then a zero-length frame
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkStatus("idle_noise_ignored", 4'b0101);
    applyStimulus(8'h55);
    checkStatus("zero_len_sync", 4'b1100);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkStatus("zero_len_in_check", 4'b1100);
    applyStimulus(8'h00);
    checkStatus("zero_len_done", 4'b0010);

    // Oversize length 0x8001 rejected at LEN_LO
    applyStimulus(8'h55);
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    checkStatus("oversize_error", 4'b0101);
    sendGoodFrame();

    // Timeout after 100 silent clocks
    applyStimulus(8'h55);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    e0 = lastDv;
    while (cyc < e0 + 99) @(negedge i_CLK);
    checkStatus("timeout_clk99_alive", 4'b1100);
    @(negedge i_CLK);
    checkStatus("timeout_clk100_error", 4'b0101);

    // Byte on the last allowed cycle keeps the frame alive
    applyStimulus(8'h55);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    e0 = lastDv;
    while (cyc < e0 + 99) @(negedge i_CLK);
    expectWrite(15'd0, 16'h1234);
    applyStimulus(8'h34);
    checkStatus("late_byte_alive", 4'b1100);
    applyStimulus(8'h47);
    checkStatus("late_byte_done", 4'b0010);

    // Asynchronous reset between HI and LO of word 1
    applyStimulus(8'h55);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    expectWrite(15'd0, 16'h1234);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    #3;
    i_RESET_n = 1'b0;
    #1;
    checkStatus("async_reset_status", 4'b0000);
    checkOutput("async_reset_data", {16'd0, o_ROM_Data}, 32'd0);
    checkOutput("async_reset_we", {31'd0, o_ROM_WE}, 32'd0);
    repeat (2) @(negedge i_CLK);
    i_RESET_n = 1'b1;
    @(negedge i_CLK);
    sendGoodFrame();

    repeat (5) @(negedge i_CLK);
    checkOutput("pending_writes", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
